// File: rtl/unidad_busqueda_inst.sv
// Instruction fetch unit: holds the PC, reads instruction memory over req/ack and
// presents each fetched word to decode, holding it under stall and redirecting on branches.
module unidad_busqueda_inst #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        stall,
    output logic [31:0] inst,
    output logic [5:0]  opcode,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4,
    output logic        inst_valid
);

    typedef enum logic [1:0] {
        StArranque = 2'd0,
        StPide     = 2'd1,
        StEntrega  = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] pc_out_q, pc_out_d;
    logic [31:0] pc_plus4_q, pc_plus4_d;
    logic        valid_q, valid_d;
    logic [31:0] pc_inc;

    assign pc_inc = pc_q + 32'd4;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StArranque;
            pc_q       <= PC_RESET;
            inst_q     <= 32'h0;
            pc_out_q   <= 32'h0;
            pc_plus4_q <= 32'h0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            inst_q     <= inst_d;
            pc_out_q   <= pc_out_d;
            pc_plus4_q <= pc_plus4_d;
            valid_q    <= valid_d;
        end
    end

    // A redirect wins over every state, including a pending stall or an ack in flight.
    always_comb begin
        state_d = state_q;
        if (branch_taken) begin
            state_d = StPide;
        end else begin
            unique case (state_q)
                StArranque: state_d = StPide;
                StPide:     if (imem_ack) state_d = StEntrega;
                StEntrega:  if (!stall) state_d = StPide;
                default:    state_d = StArranque;
            endcase
        end
    end

    always_comb begin
        pc_d       = pc_q;
        inst_d     = inst_q;
        pc_out_d   = pc_out_q;
        pc_plus4_d = pc_plus4_q;
        valid_d    = valid_q;
        if (branch_taken) begin
            pc_d    = {branch_target[31:2], 2'b00};
            valid_d = 1'b0;
        end else if (state_q == StPide && imem_ack) begin
            inst_d     = imem_rdata;
            pc_out_d   = pc_q;
            pc_plus4_d = pc_inc;
            pc_d       = pc_inc;
            valid_d    = 1'b1;
        end else if (state_q == StEntrega && !stall) begin
            valid_d = 1'b0;
        end
    end

    always_comb begin
        imem_req   = (state_q == StPide);
        imem_addr  = pc_q;
        inst       = inst_q;
        opcode     = inst_q[31:26];
        pc_out     = pc_out_q;
        pc_plus4   = pc_plus4_q;
        inst_valid = valid_q;
    end

endmodule

// File: tb/tb_unidad_busqueda_inst.sv
// Directed bench for unidad_busqueda_inst: two instances (normal and wrapping reset PC)
// share the stimulus; outputs are checked 1 time unit after each rising edge.
module tb_unidad_busqueda_inst;

    logic        clk;
    logic        rst_n;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        stall;

    logic        req_a, req_b;
    logic [31:0] addr_a, addr_b;
    logic [31:0] inst_a, inst_b;
    logic [5:0]  opc_a, opc_b;
    logic [31:0] pco_a, pco_b;
    logic [31:0] pc4_a, pc4_b;
    logic        val_a, val_b;

    int checks = 0;
    int errors = 0;

    unidad_busqueda_inst #(.PC_RESET(32'h0000_0040)) dut_a (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req      (req_a),
        .imem_addr     (addr_a),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .stall         (stall),
        .inst          (inst_a),
        .opcode        (opc_a),
        .pc_out        (pco_a),
        .pc_plus4      (pc4_a),
        .inst_valid    (val_a)
    );

    unidad_busqueda_inst #(.PC_RESET(32'hFFFF_FFFC)) dut_b (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req      (req_b),
        .imem_addr     (addr_b),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .stall         (stall),
        .inst          (inst_b),
        .opcode        (opc_b),
        .pc_out        (pco_b),
        .pc_plus4      (pc4_b),
        .inst_valid    (val_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n         = 1'b0;
        imem_ack      = 1'b0;
        imem_rdata    = 32'h0;
        branch_taken  = 1'b0;
        branch_target = 32'h0;
        stall         = 1'b0;
        step();
        step();
        chk("rst_req",    {31'b0, req_a}, 32'd0);
        chk("rst_addr",   addr_a, 32'h40);
        chk("rst_valid",  {31'b0, val_a}, 32'd0);
        chk("rst_inst",   inst_a, 32'h0);
        chk("rst_opcode", {26'b0, opc_a}, 32'd0);
        chk("rst_pcout",  pco_a, 32'h0);
        chk("rst_pc4",    pc4_a, 32'h0);
        chk("rst_addr_b", addr_b, 32'hFFFF_FFFC);

        // Reset release and first fetch with same-cycle ack
        rst_n = 1'b1;
        step();
        chk("first_req",  {31'b0, req_a}, 32'd1);
        chk("first_addr", addr_a, 32'h40);
        imem_ack   = 1'b1;
        imem_rdata = 32'h0000_0020;
        step();
        chk("f1_valid",  {31'b0, val_a}, 32'd1);
        chk("f1_inst",   inst_a, 32'h20);
        chk("f1_opcode", {26'b0, opc_a}, 32'd0);
        chk("f1_pcout",  pco_a, 32'h40);
        chk("f1_pc4",    pc4_a, 32'h44);
        chk("f1_req",    {31'b0, req_a}, 32'd0);
        chk("f1_addr",   addr_a, 32'h44);
        chk("wrap_pcout", pco_b, 32'hFFFF_FFFC);
        chk("wrap_pc4",   pc4_b, 32'h0);

        // Stall hold for 3 cycles
        imem_ack = 1'b0;
        stall    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_valid", {31'b0, val_a}, 32'd1);
            chk("stall_inst",  inst_a, 32'h20);
            chk("stall_pcout", pco_a, 32'h40);
            chk("stall_req",   {31'b0, req_a}, 32'd0);
        end
        stall = 1'b0;
        step();
        chk("rel_valid", {31'b0, val_a}, 32'd0);
        chk("rel_req",   {31'b0, req_a}, 32'd1);
        chk("rel_addr",  addr_a, 32'h44);
        chk("wrap_addr2", addr_b, 32'h0);

        // Two wait states before ack
        for (int i = 0; i < 2; i++) begin
            step();
            chk("wait_req",   {31'b0, req_a}, 32'd1);
            chk("wait_addr",  addr_a, 32'h44);
            chk("wait_valid", {31'b0, val_a}, 32'd0);
        end
        imem_ack   = 1'b1;
        imem_rdata = 32'hFC00_0001;
        step();
        chk("w_valid",  {31'b0, val_a}, 32'd1);
        chk("w_inst",   inst_a, 32'hFC00_0001);
        chk("w_opcode", {26'b0, opc_a}, 32'h3F);
        chk("w_pcout",  pco_a, 32'h44);
        chk("w_pc4",    pc4_a, 32'h48);
        chk("w_req",    {31'b0, req_a}, 32'd0);
        imem_ack = 1'b0;
        step();
        chk("nodup_valid", {31'b0, val_a}, 32'd0);
        chk("nodup_addr",  addr_a, 32'h48);

        // Branch in PIDE with simultaneous ack: data discarded
        branch_taken  = 1'b1;
        branch_target = 32'h0000_1003;
        imem_ack      = 1'b1;
        imem_rdata    = 32'hDEAD_BEEF;
        step();
        chk("br_valid", {31'b0, val_a}, 32'd0);
        chk("br_req",   {31'b0, req_a}, 32'd1);
        chk("br_addr",  addr_a, 32'h1000);
        chk("br_inst",  inst_a, 32'hFC00_0001);
        branch_taken = 1'b0;
        imem_rdata   = 32'h8C00_0000;
        step();
        chk("bt_valid",  {31'b0, val_a}, 32'd1);
        chk("bt_inst",   inst_a, 32'h8C00_0000);
        chk("bt_opcode", {26'b0, opc_a}, 32'h23);
        chk("bt_pcout",  pco_a, 32'h1000);
        chk("bt_pc4",    pc4_a, 32'h1004);
        imem_ack = 1'b0;
        step();
        chk("pre_ar_req", {31'b0, req_a}, 32'd1);

        // Asynchronous reset between edges while requesting
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_req",   {31'b0, req_a}, 32'd0);
        chk("ar_valid", {31'b0, val_a}, 32'd0);
        chk("ar_addr",  addr_a, 32'h40);
        chk("ar_pcout", pco_a, 32'h0);
        step();
        rst_n = 1'b1;
        step();
        chk("rs_req",  {31'b0, req_a}, 32'd1);
        chk("rs_addr", addr_a, 32'h40);
        imem_ack   = 1'b1;
        imem_rdata = 32'h0000_0020;
        step();
        chk("rs_valid", {31'b0, val_a}, 32'd1);
        chk("rs_pcout", pco_a, 32'h40);
        chk("rs_pc4",   pc4_a, 32'h44);

        // Redirect is not blocked by stall in ENTREGA
        imem_ack      = 1'b0;
        stall         = 1'b1;
        branch_taken  = 1'b1;
        branch_target = 32'h0000_0300;
        step();
        chk("bs_valid", {31'b0, val_a}, 32'd0);
        chk("bs_req",   {31'b0, req_a}, 32'd1);
        chk("bs_addr",  addr_a, 32'h300);
        branch_taken = 1'b0;
        stall        = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
